// File: rtl/mem_arbiter_3p_pkg.sv
// Shared encodings for the three-port memory arbiter: read-owner tags, FSM states and
// request/grant bit positions.
package mem_arbiter_3p_pkg;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnL    = 2'd1,
    OwnD    = 2'd2,
    OwnI    = 2'd3
  } owner_e;

  typedef enum logic {
    StBoot = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned ReqL = 0;
  localparam int unsigned ReqD = 1;
  localparam int unsigned ReqI = 2;

  // Grant vector is one-hot or zero, so the order of tests here does not matter.
  function automatic owner_e owner_of(input logic [2:0] gnt);
    owner_e own;
    own = OwnNone;
    if (gnt[ReqL]) begin
      own = OwnL;
    end else if (gnt[ReqD]) begin
      own = OwnD;
    end else if (gnt[ReqI]) begin
      own = OwnI;
    end
    return own;
  endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Three-way fixed-priority picker (L > D > I) with a promote input that lifts I to the top.
module arb_prio_pick
  import mem_arbiter_3p_pkg::*;
(
  input  logic [2:0] req,
  input  logic       promote,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    if (promote && req[ReqI]) begin
      gnt[ReqI] = 1'b1;
    end else if (req[ReqL]) begin
      gnt[ReqL] = 1'b1;
    end else if (req[ReqD]) begin
      gnt[ReqD] = 1'b1;
    end else if (req[ReqI]) begin
      gnt[ReqI] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter_3p.sv
// Shares one single-port synchronous SRAM between boot loader (L), core data (D) and
// instruction fetch (I); read data returns one cycle after the grant to the recorded owner.
module mem_arbiter_3p
  import mem_arbiter_3p_pkg::*;
#(
  parameter int unsigned AW           = 30,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned MW          = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_boot,
  input  logic          i_l_req,
  input  logic          i_l_we,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_wdata,
  output logic          o_l_gnt,
  output logic          o_l_rvalid,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  input  logic [MW-1:0] i_d_mask,
  output logic          o_d_gnt,
  output logic          o_d_rvalid,
  input  logic          i_i_req,
  input  logic [AW-1:0] i_i_addr,
  output logic          o_i_gnt,
  output logic          o_i_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [MW-1:0] o_mem_mask,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] StarveMax = CW'(STARVE_LIMIT);

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  owner_e        rd_owner_q, rd_owner_d;
  owner_e        win;
  logic          run;
  logic          promote;
  logic          i_denied;
  logic [2:0]    req;
  logic [2:0]    gnt;

  assign run     = (state_q == StRun);
  // In BOOT only the loader may compete.
  assign req     = {i_i_req & run, i_d_req & run, i_l_req};
  assign promote = run && (starve_q == StarveMax);

  arb_prio_pick u_pick (
    .req     (req),
    .promote (promote),
    .gnt     (gnt)
  );

  assign o_l_gnt  = gnt[ReqL];
  assign o_d_gnt  = gnt[ReqD];
  assign o_i_gnt  = gnt[ReqI];
  assign win      = owner_of(gnt);
  assign i_denied = run && i_i_req && !gnt[ReqI];

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_mask  = '0;
    unique case (win)
      OwnL: begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_l_we;
        o_mem_addr  = i_l_addr;
        o_mem_wdata = i_l_wdata;
        o_mem_mask  = '1;
      end
      OwnD: begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_d_we;
        o_mem_addr  = i_d_addr;
        o_mem_wdata = i_d_wdata;
        o_mem_mask  = i_d_mask;
      end
      OwnI: begin
        o_mem_en   = 1'b1;
        o_mem_addr = i_i_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = i_boot ? StBoot : StRun;
    starve_d   = '0;
    rd_owner_d = OwnNone;
    if (i_denied) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    end
    if (o_mem_en && !o_mem_we) begin
      rd_owner_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      starve_q   <= '0;
      rd_owner_q <= OwnNone;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign o_l_rvalid = (rd_owner_q == OwnL);
  assign o_d_rvalid = (rd_owner_q == OwnD);
  assign o_i_rvalid = (rd_owner_q == OwnI);
  assign o_rdata    = (rd_owner_q != OwnNone) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter_3p.sv
// Directed bench for mem_arbiter_3p with a behavioural SRAM whose unwritten words read
// back as 0xC0DE_0000 | addr[7:0].
module tb_mem_arbiter_3p;

  logic        clk;
  logic        rst_n;
  logic        boot;
  logic        l_req, l_we;
  logic [29:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt, l_rvalid;
  logic        d_req, d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mask;
  logic        d_gnt, d_rvalid;
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter_3p dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_boot      (boot),
    .i_l_req     (l_req),
    .i_l_we      (l_we),
    .i_l_addr    (l_addr),
    .i_l_wdata   (l_wdata),
    .o_l_gnt     (l_gnt),
    .o_l_rvalid  (l_rvalid),
    .i_d_req     (d_req),
    .i_d_we      (d_we),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .i_d_mask    (d_mask),
    .o_d_gnt     (d_gnt),
    .o_d_rvalid  (d_rvalid),
    .i_i_req     (i_req),
    .i_i_addr    (i_addr),
    .o_i_gnt     (i_gnt),
    .o_i_rvalid  (i_rvalid),
    .o_rdata     (rdata),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_mask  (mem_mask),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: 256 words, byte-masked writes, one-cycle read latency.
  logic [31:0]  mem [256];
  logic [255:0] wvld = '0;
  logic [31:0]  wr_word;

  function automatic logic [31:0] rd_word(input logic [29:0] a);
    return wvld[a[7:0]] ? mem[a[7:0]] : (32'hC0DE_0000 | {24'h0, a[7:0]});
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wr_word = rd_word(mem_addr);
        for (int b = 0; b < 4; b++) begin
          if (mem_mask[b]) wr_word[8*b +: 8] = mem_wdata[8*b +: 8];
        end
        mem[mem_addr[7:0]]  <= wr_word;
        wvld[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_rdata <= rd_word(mem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Grant and rvalid vectors are packed {L, D, I}.
  task automatic chk_gnt(input string tag, input logic [2:0] exp);
    chk(tag, {29'h0, l_gnt, d_gnt, i_gnt}, {29'h0, exp});
  endtask

  task automatic chk_rv(input string tag, input logic [2:0] exp);
    chk(tag, {29'h0, l_rvalid, d_rvalid, i_rvalid}, {29'h0, exp});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"},
        {24'h0, l_gnt, l_rvalid, d_gnt, d_rvalid, i_gnt, i_rvalid, mem_en, mem_we}, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_addr"}, {2'b0, mem_addr}, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mask"}, {28'h0, mem_mask}, 32'h0);
  endtask

  task automatic clear_reqs();
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_mask = '0;
    i_req = 1'b0; i_addr = '0;
  endtask

  logic [2:0]  prev_g;
  logic [29:0] prev_a;
  logic [2:0]  exp_g;

  initial begin
    rst_n = 1'b0;
    boot  = 1'b1;
    clear_reqs();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // BOOT: loader writes 0..3 while D and I request and must be ignored
    d_req = 1'b1; d_addr = 30'h10;
    i_req = 1'b1; i_addr = 30'h40;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      l_req = 1'b1; l_we = 1'b1; l_addr = 30'(n); l_wdata = 32'hA5A5_0000 + 32'(n);
      #1;
      chk_gnt("boot_wr_gnt", 3'b100);
      chk("boot_wr_we", {31'h0, mem_we}, 32'h1);
      chk("boot_wr_addr", {2'b0, mem_addr}, 32'(n));
      chk("boot_wr_wdata", mem_wdata, 32'hA5A5_0000 + 32'(n));
      chk("boot_wr_mask", {28'h0, mem_mask}, 32'hF);
    end
    @(negedge clk);
    l_we = 1'b0; l_addr = 30'h2;
    #1;
    chk_gnt("boot_rd_gnt", 3'b100);
    chk("boot_rd_en_we", {30'h0, mem_en, mem_we}, 32'h2);
    @(negedge clk);
    l_req = 1'b0;
    #1;
    chk_rv("boot_rd_rvalid", 3'b100);
    chk("boot_rd_rdata", rdata, 32'hA5A5_0002);
    chk_gnt("boot_di_blocked", 3'b000);

    // Leaving BOOT: the switching cycle is still arbitrated as BOOT
    @(negedge clk);
    boot = 1'b0;
    #1;
    chk_gnt("boot_exit_cycle", 3'b000);
    chk_rv("boot_exit_rv", 3'b000);
    @(negedge clk);
    #1;
    chk_gnt("run_d_over_i", 3'b010);
    chk("run_d_addr", {2'b0, mem_addr}, 32'h10);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk_rv("run_d_rvalid", 3'b010);
    chk("run_d_rdata", rdata, 32'hC0DE_0010);
    chk_gnt("run_i_gnt", 3'b001);
    chk("run_i_addr", {2'b0, mem_addr}, 32'h40);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk_rv("run_i_rvalid", 3'b001);
    chk("run_i_rdata", rdata, 32'hC0DE_0040);
    chk("run_idle_en", {31'h0, mem_en}, 32'h0);

    // Starvation: D held for 10 cycles, I promoted on the 5th and 10th
    prev_g = 3'b000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      d_req = 1'b1; d_addr = 30'h11;
      i_req = 1'b1; i_addr = 30'h41;
      #1;
      exp_g = (c == 4 || c == 9) ? 3'b001 : 3'b010;
      chk_gnt("starve_gnt", exp_g);
      if (c > 0) chk_rv("starve_rv", prev_g);
      prev_g = exp_g;
    end
    @(negedge clk);
    clear_reqs();
    #1;
    chk_rv("starve_last_rv", 3'b001);
    chk("starve_last_rdata", rdata, 32'hC0DE_0041);

    // D masked write: no rvalid follows, then read back the merged word
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_mask = 4'b0010; d_wdata = 32'h0000_BB00;
    #1;
    chk_gnt("dwr_gnt", 3'b010);
    chk("dwr_we", {31'h0, mem_we}, 32'h1);
    chk("dwr_mask", {28'h0, mem_mask}, 32'h2);
    chk("dwr_wdata", mem_wdata, 32'h0000_BB00);
    chk("dwr_addr", {2'b0, mem_addr}, 32'h20);
    @(negedge clk);
    clear_reqs();
    #1;
    chk_rv("dwr_no_rvalid", 3'b000);
    chk("dwr_no_rdata", rdata, 32'h0);
    @(negedge clk);
    d_req = 1'b1; d_addr = 30'h20;
    #1;
    chk_gnt("drd_gnt", 3'b010);
    @(negedge clk);
    clear_reqs();
    #1;
    chk_rv("drd_rvalid", 3'b010);
    chk("drd_merged", rdata, 32'hC0DE_BB20);

    // Alternating D/I reads at full throughput
    prev_g = 3'b000;
    prev_a = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      clear_reqs();
      if (k % 2 == 0) begin
        d_req = 1'b1; d_addr = 30'h30 + 30'(k); exp_g = 3'b010;
      end else begin
        i_req = 1'b1; i_addr = 30'h50 + 30'(k); exp_g = 3'b001;
      end
      #1;
      chk_gnt("alt_gnt", exp_g);
      chk("alt_addr", {2'b0, mem_addr}, (k % 2 == 0) ? 32'h30 + 32'(k) : 32'h50 + 32'(k));
      if (k > 0) begin
        chk_rv("alt_rv", prev_g);
        chk("alt_rdata", rdata, 32'hC0DE_0000 | {2'b0, prev_a});
      end
      prev_g = exp_g;
      prev_a = mem_addr;
    end
    @(negedge clk);
    clear_reqs();
    #1;
    chk_rv("alt_last_rv", 3'b001);
    chk("alt_last_rdata", rdata, 32'hC0DE_0055);

    // Reset between an I read grant and its rvalid
    @(negedge clk);
    i_req = 1'b1; i_addr = 30'h60;
    #1;
    chk_gnt("rst_i_gnt", 3'b001);
    #1;
    rst_n = 1'b0;
    clear_reqs();
    #1;
    chk_all_zero("rst_assert");
    repeat (2) begin
      @(negedge clk);
      #1;
      chk_all_zero("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    d_req = 1'b1; d_addr = 30'h70;
    #1;
    chk_gnt("post_rst_boot", 3'b000);
    chk_rv("post_rst_rv", 3'b000);
    @(negedge clk);
    #1;
    chk_gnt("post_rst_run", 3'b010);
    chk_rv("post_rst_no_i_rv", 3'b000);
    @(negedge clk);
    clear_reqs();
    #1;
    chk_rv("post_rst_d_rv", 3'b010);
    chk("post_rst_rdata", rdata, 32'hC0DE_0070);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
